clint: RTL and testbench
========================

# clint

Core-local interrupt/trap controller for the rooth core. Watches the instruction in execute, the external interrupt line and `mstatus`, and sequences trap entry (`ecall`, `ebreak`, external interrupt) and trap return (`mret`). It writes `mepc`, `mcause` and `mstatus` through the CSR file's client write port, which has priority over core writes. It reads `mtvec`, `mepc` and `mstatus` back from the CSR file, stalls the pipeline while it runs, and issues the redirect address to fetch.

## Interface
- `IRQ_CAUSE`, default 32'h8000_000B: `mcause` value for the external interrupt (machine external, interrupt bit set).
- Widths come from shared defines: `CPU_WIDTH` = 32, `CSR_ADDR_WIDTH` = 12.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inst_i` input 32: instruction currently in execute.
- `inst_addr_i` input 32: PC of `inst_i`.
- `jump_flag_i` input 1: execute is redirecting this cycle.
- `jump_addr_i` input 32: redirect target when `jump_flag_i` is high.
- `irq_i` input 1: level-sensitive external interrupt request.
- `csr_mtvec_i` input 32: current `mtvec`.
- `csr_mepc_i` input 32: current `mepc`.
- `csr_mstatus_i` input 32: current `mstatus`.
- `client_csr_wr_en_o` output 1: CSR client write strobe.
- `client_csr_wr_adder_o` output 12: CSR address to write.
- `client_csr_wr_data_o` output 32: data to write.
- `hold_flag_o` output 1: stall request to the pipeline.
- `int_assert_o` output 1: one-cycle redirect pulse.
- `int_addr_o` output 32: redirect target, valid with `int_assert_o`.

## Operation
- Events are decoded only in `IDLE`:
  - `ECALL`: `inst_i` = 32'h0000_0073.
  - `EBREAK`: `inst_i` = 32'h0010_0073.
  - `MRET`: `inst_i` = 32'h3020_0073.
  - `IRQ`: `irq_i` high and `csr_mstatus_i[3]` (MIE) high.
- Priority: `ECALL`/`EBREAK` > `MRET` > `IRQ`. A losing `IRQ` stays pending (level input) and is taken on a later `IDLE` cycle.
- On event acceptance, capture:
  - `cause_q`: 11 for ecall, 3 for ebreak, `IRQ_CAUSE` for the interrupt.
  - `epc_q`: `jump_addr_i` if `jump_flag_i` is high, else `inst_addr_i`.
- Trap-entry FSM:
  - `IDLE` → `W_MEPC`: write `CSR_MEPC` ← `epc_q`.
  - `W_MEPC` → `W_MCAUSE`: write `CSR_MCAUSE` ← `cause_q`.
  - `W_MCAUSE` → `W_MSTATUS`: write `CSR_MSTATUS` ← `mstatus` with bit 7 (MPIE) ← old bit 3 and bit 3 (MIE) ← 0; all other bits unchanged.
  - `W_MSTATUS` → `JUMP`: `int_assert_o` = 1, `int_addr_o` = trap vector.
  - `JUMP` → `IDLE`.
- Return FSM:
  - `IDLE` → `R_MSTATUS`: write `CSR_MSTATUS` with bit 3 ← old bit 7 and bit 7 ← 1.
  - `R_MSTATUS` → `R_JUMP`: `int_assert_o` = 1, `int_addr_o` = `csr_mepc_i`.
  - `R_JUMP` → `IDLE`.
- Trap vector is `{csr_mtvec_i[31:2], 2'b00}` (direct mode; see Configuration).
- `client_csr_wr_*` are decoded from the current state; all three are 0 in `IDLE`, `JUMP` and `R_JUMP`.
- `hold_flag_o` = (state ≠ `IDLE`) OR (event accepted this cycle, combinational).
- Events and `irq_i` arriving while not in `IDLE` are ignored. No nesting.

## Timing
- Reset: while `rst` is high at the clock edge, the state goes to `IDLE` and `cause_q`/`epc_q` go to 0. All outputs are 0 while `rst` is high.
- Reset in mid-sequence abandons the sequence immediately. CSR writes already committed stay; no further writes or redirects are issued.
- Each CSR write commits at the end of its state's cycle. A later state reading `csr_mstatus_i` or `csr_mepc_i` therefore sees the updated value (e.g. `mret` after a trap-handler write of `mepc`).
- Trap entry: event in cycle N; writes in N+1..N+3; `int_assert_o` in N+4; `hold_flag_o` high N..N+4.
- Return: event in N; write in N+1; `int_assert_o` in N+2; `hold_flag_o` high N..N+2.
- `IDLE` is re-entered one cycle after the redirect cycle. A back-to-back event needs `hold_flag_o` released for at least one cycle.

## Configuration
- `CLINT_VECTORED_EN` defined: when `csr_mtvec_i[1:0]` = 2'b01 and the cause is an interrupt, the vector is `{mtvec[31:2],2'b00}` + 4 × `cause[30:0]`. Exceptions always use the base.
- Not defined: always direct mode. `mtvec[1:0]` is ignored.

## Structure
- Shared defines file holds:
  - `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MSTATUS`.
  - `INST_ECALL`, `INST_EBREAK`, `INST_MRET`.
  - Cause codes, the `mstatus` MIE/MPIE bit indices, `CPU_WIDTH` and `CSR_ADDR_WIDTH`.
- FSM state encoding is local to the module.
- Single module; no sub-module.

## Test plan
- ecall at PC 0x100, `mstatus` = 0x8, `mtvec` = 0x400:
  - writes `mepc` = 0x100, `mcause` = 11, `mstatus` = 0x80.
  - `int_assert_o` in cycle 4 with `int_addr_o` = 0x400.
  - `hold_flag_o` high for 5 cycles.
- `irq_i` = 1 with `mstatus` = 0 → no action. Set `mstatus` = 0x8 → `mcause` = 0x8000_000B, `epc` = current PC.
- ecall and `irq_i` in the same cycle → ecall serviced (`mcause` = 11). The IRQ is not taken until MIE is restored.
- mret with `mstatus` = 0x80, `mepc` = 0x104 → `mstatus` written 0x88, then redirect to 0x104 two cycles after detection.
- `rst` asserted in `W_MCAUSE` → no `mstatus` write, no redirect, all outputs 0, FSM in `IDLE`.
- With `CLINT_VECTORED_EN`, `mtvec` = 0x401, IRQ → redirect to 0x42C. The same IRQ without the macro → redirect to 0x400.

Source files
------------

// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the core-local interrupt/trap controller (clint):
// datapath widths, CSR addresses written by the controller, the system
// instruction encodings it decodes, synchronous-exception cause codes and the
// mstatus bit positions it manipulates.
// -----------------------------------------------------------------------------
package clint_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  // CSR addresses (machine-mode trap CSRs)
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

  // System instruction encodings
  localparam logic [CPU_WIDTH-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [CPU_WIDTH-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [CPU_WIDTH-1:0] INST_MRET   = 32'h3020_0073;

  // Synchronous exception causes (interrupt bit clear)
  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL  = 32'd11;
  localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK = 32'd3;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/clint.sv
// -----------------------------------------------------------------------------
// clint -- core-local interrupt/trap controller
//
// Decodes ecall / ebreak / mret in execute and the level-sensitive external
// interrupt (gated by mstatus.MIE), then sequences trap entry
// (mepc -> mcause -> mstatus -> redirect) or trap return
// (mstatus -> redirect to mepc). CSR writes go out on the client write port,
// the pipeline is held for the whole sequence, and fetch gets a one-cycle
// redirect pulse.
//
// Optional feature: define CLINT_VECTORED_EN to honour vectored mtvec mode
// (mtvec[1:0] = 2'b01) for interrupts; otherwise the vector is always the
// mtvec base.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_i, inst_addr_i      instruction in execute and its PC
//   jump_flag_i, jump_addr_i execute redirect (used as epc when active)
//   irq_i                    external interrupt request (level)
//   csr_mtvec_i/mepc_i/mstatus_i  current CSR values
//   client_csr_wr_en_o/adder_o/data_o  CSR client write port
//   hold_flag_o              pipeline stall request
//   int_assert_o, int_addr_o one-cycle redirect pulse and target
//
// Handshake: there is no back-pressure. A client CSR write is a single-cycle
// strobe that the CSR file always accepts at the end of that cycle;
// int_assert_o is a single-cycle pulse that fetch always accepts.
// -----------------------------------------------------------------------------
module clint
  import clint_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] IRQ_CAUSE = 32'h8000_000B
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CPU_WIDTH-1:0]      inst_i,
  input  logic [CPU_WIDTH-1:0]      inst_addr_i,
  input  logic                      jump_flag_i,
  input  logic [CPU_WIDTH-1:0]      jump_addr_i,
  input  logic                      irq_i,
  input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
  output logic                      client_csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] client_csr_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      client_csr_wr_data_o,
  output logic                      hold_flag_o,
  output logic                      int_assert_o,
  output logic [CPU_WIDTH-1:0]      int_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_JUMP,
    S_R_MSTATUS,
    S_R_JUMP
  } state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] cause_q, cause_d;
  logic [CPU_WIDTH-1:0] epc_q,   epc_d;

  logic                 is_ecall, is_ebreak, is_mret, is_irq;
  logic [CPU_WIDTH-1:0] trap_vec;
  logic [CPU_WIDTH-1:0] mstatus_enter, mstatus_ret;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign is_irq    = irq_i & csr_mstatus_i[MSTATUS_MIE];

  // Trap entry: stash MIE into MPIE and disable interrupts.
  always_comb begin
    mstatus_enter               = csr_mstatus_i;
    mstatus_enter[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
    mstatus_enter[MSTATUS_MIE]  = 1'b0;
  end

  // Trap return: restore MIE from MPIE and set MPIE.
  always_comb begin
    mstatus_ret               = csr_mstatus_i;
    mstatus_ret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
    mstatus_ret[MSTATUS_MPIE] = 1'b1;
  end

`ifdef CLINT_VECTORED_EN
  // Vectored mode only offsets interrupts; 4*cause[30:0] truncated to 32 bits.
  always_comb begin
    trap_vec = {csr_mtvec_i[CPU_WIDTH-1:2], 2'b00};
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[CPU_WIDTH-1])
      trap_vec = trap_vec + {cause_q[CPU_WIDTH-3:0], 2'b00};
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
  assign trap_vec          = {csr_mtvec_i[CPU_WIDTH-1:2], 2'b00};
`endif

  always_comb begin
    state_d               = state_q;
    cause_d               = cause_q;
    epc_d                 = epc_q;
    client_csr_wr_en_o    = 1'b0;
    client_csr_wr_adder_o = '0;
    client_csr_wr_data_o  = '0;
    int_assert_o          = 1'b0;
    int_addr_o            = '0;
    hold_flag_o           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Priority: ecall/ebreak > mret > irq. A losing irq is a level and
        // is simply seen again on a later idle cycle.
        if (is_ecall || is_ebreak || (is_irq && !is_mret)) begin
          state_d     = S_W_MEPC;
          cause_d     = is_ecall  ? CAUSE_ECALL  :
                        is_ebreak ? CAUSE_EBREAK : IRQ_CAUSE;
          epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
          hold_flag_o = 1'b1;
        end else if (is_mret) begin
          state_d     = S_R_MSTATUS;
          hold_flag_o = 1'b1;
        end
      end
      S_W_MEPC: begin
        client_csr_wr_en_o    = 1'b1;
        client_csr_wr_adder_o = CSR_MEPC;
        client_csr_wr_data_o  = epc_q;
        state_d               = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        client_csr_wr_en_o    = 1'b1;
        client_csr_wr_adder_o = CSR_MCAUSE;
        client_csr_wr_data_o  = cause_q;
        state_d               = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        client_csr_wr_en_o    = 1'b1;
        client_csr_wr_adder_o = CSR_MSTATUS;
        client_csr_wr_data_o  = mstatus_enter;
        state_d               = S_JUMP;
      end
      S_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = trap_vec;
        state_d      = S_IDLE;
      end
      S_R_MSTATUS: begin
        client_csr_wr_en_o    = 1'b1;
        client_csr_wr_adder_o = CSR_MSTATUS;
        client_csr_wr_data_o  = mstatus_ret;
        state_d               = S_R_JUMP;
      end
      S_R_JUMP: begin
        // mepc is read here, after any handler write has committed.
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset silences every output in the same cycle, so an abandoned
    // sequence issues no further writes or redirects.
    if (rst) begin
      client_csr_wr_en_o    = 1'b0;
      client_csr_wr_adder_o = '0;
      client_csr_wr_data_o  = '0;
      int_assert_o          = 1'b0;
      int_addr_o            = '0;
      hold_flag_o           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

endmodule

// File: tb/tb_clint.sv
// -----------------------------------------------------------------------------
// tb_clint -- bench for clint. Acts as the CSR file (client writes win over
// core writes), drives directed scenarios and a randomized phase, and compares
// every cycle's outputs with a queue-of-actions reference model.
// -----------------------------------------------------------------------------
module tb_clint;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] inst_i = NOP, inst_addr_i = '0, jump_addr_i = '0;
  logic        jump_flag_i = 1'b0, irq_i = 1'b0;
  logic        wr_en, hold, as;
  logic [11:0] wr_addr;
  logic [31:0] wr_data, int_addr;

  // bench-side CSR file
  logic [31:0] csr_mtvec = '0, csr_mepc = '0, csr_mstatus = '0, csr_mcause = '0;
  logic        core_we = 1'b0;
  logic [11:0] core_addr = '0;
  logic [31:0] core_data = '0;

  clint dut (
    .clk                  (clk),
    .rst                  (rst),
    .inst_i               (inst_i),
    .inst_addr_i          (inst_addr_i),
    .jump_flag_i          (jump_flag_i),
    .jump_addr_i          (jump_addr_i),
    .irq_i                (irq_i),
    .csr_mtvec_i          (csr_mtvec),
    .csr_mepc_i           (csr_mepc),
    .csr_mstatus_i        (csr_mstatus),
    .client_csr_wr_en_o   (wr_en),
    .client_csr_wr_adder_o(wr_addr),
    .client_csr_wr_data_o (wr_data),
    .hold_flag_o          (hold),
    .int_assert_o         (as),
    .int_addr_o           (int_addr)
  );

  always @(posedge clk) begin
    if (wr_en) begin
      case (wr_addr)
        A_MSTATUS: csr_mstatus <= wr_data;
        A_MEPC:    csr_mepc    <= wr_data;
        A_MCAUSE:  csr_mcause  <= wr_data;
        A_MTVEC:   csr_mtvec   <= wr_data;
        default: ;
      endcase
    end else if (core_we) begin
      case (core_addr)
        A_MSTATUS: csr_mstatus <= core_data;
        A_MEPC:    csr_mepc    <= core_data;
        A_MCAUSE:  csr_mcause  <= core_data;
        A_MTVEC:   csr_mtvec   <= core_data;
        default: ;
      endcase
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Each accepted event schedules its remaining per-cycle actions.
  typedef enum int {K_MEPC, K_MCAUSE, K_MSTAT_ENTER, K_VEC, K_MSTAT_RET, K_RET} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] epc;
    logic [31:0] cause;
  } step_t;
  step_t exp_q[$];

  int n_pass = 0, n_total = 0;
  int ev_age = 0, hold_cnt = 0, red_cnt = 0, red_delay = 0;
  logic [31:0] red_addr = '0;

  function automatic logic [31:0] vec_of(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] v;
    v = mtvec & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause[31]) v = v + (cause & 32'h7FFF_FFFF) * 4;
`endif
    return v;
  endfunction

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause);
    step_t s;
    s.epc = epc; s.cause = cause;
    s.kind = K_MEPC;        exp_q.push_back(s);
    s.kind = K_MCAUSE;      exp_q.push_back(s);
    s.kind = K_MSTAT_ENTER; exp_q.push_back(s);
    s.kind = K_VEC;         exp_q.push_back(s);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic        e_we, e_as, e_hold, acc;
    logic [11:0] e_ad;
    logic [31:0] e_wd, e_ia, epc;
    step_t       s;
    e_we = 0; e_as = 0; e_hold = 0; e_ad = '0; e_wd = '0; e_ia = '0; acc = 0;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      epc = jump_flag_i ? jump_addr_i : inst_addr_i;
      acc = 1;
      if (inst_i == ECALL)                  push_trap(epc, 32'd11);
      else if (inst_i == EBREAK)            push_trap(epc, 32'd3);
      else if (inst_i == MRET) begin
        s.epc = '0; s.cause = '0;
        s.kind = K_MSTAT_RET; exp_q.push_back(s);
        s.kind = K_RET;       exp_q.push_back(s);
      end
      else if (irq_i && csr_mstatus[3])     push_trap(epc, 32'h8000_000B);
      else acc = 0;
      e_hold = acc;
    end else begin
      s = exp_q.pop_front();
      e_hold = 1;
      case (s.kind)
        K_MEPC:        begin e_we = 1; e_ad = A_MEPC;    e_wd = s.epc;   end
        K_MCAUSE:      begin e_we = 1; e_ad = A_MCAUSE;  e_wd = s.cause; end
        K_MSTAT_ENTER: begin e_we = 1; e_ad = A_MSTATUS;
                         e_wd = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0); end
        K_VEC:         begin e_as = 1; e_ia = vec_of(csr_mtvec, s.cause); end
        K_MSTAT_RET:   begin e_we = 1; e_ad = A_MSTATUS;
                         e_wd = (csr_mstatus & ~32'h08) | 32'h80 | (csr_mstatus[7] ? 32'h8 : 32'h0); end
        default:       begin e_as = 1; e_ia = csr_mepc; end
      endcase
    end

    n_total++;
    if (wr_en === e_we && wr_addr === e_ad && wr_data === e_wd &&
        hold === e_hold && as === e_as && int_addr === e_ia) n_pass++;
    else $display("FAIL cycle_outputs @%0t: got we=%b ad=%h wd=%h hold=%b as=%b ia=%h expected we=%b ad=%h wd=%h hold=%b as=%b ia=%h",
                  $time, wr_en, wr_addr, wr_data, hold, as, int_addr,
                  e_we, e_ad, e_wd, e_hold, e_as, e_ia);

    // bookkeeping for the directed literal checks
    if (acc) begin ev_age = 0; hold_cnt = 0; end
    else ev_age++;
    if (hold) hold_cnt++;
    if (as) begin red_cnt++; red_addr = int_addr; red_delay = ev_age; end
  end

  // ---------------- driver tasks ----------------
  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    core_we = 1; core_addr = a; core_data = d;
    @(posedge clk); #1;
    core_we = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    inst_i = ins; inst_addr_i = pc;
    @(posedge clk); #1;
    inst_i = NOP;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int saved_red;
    logic [31:0] saved_mcause;
    int r;
    idle(3);
    rst = 0;

    // ecall at 0x100 with MIE set
    csr_write(A_MSTATUS, 32'h8);
    csr_write(A_MTVEC, 32'h400);
    issue(ECALL, 32'h100);
    idle(6);
    check32("ecall_mepc", csr_mepc, 32'h100);
    check32("ecall_mcause", csr_mcause, 32'd11);
    check32("ecall_mstatus", csr_mstatus, 32'h80);
    check32("ecall_vec", red_addr, 32'h400);
    check32("ecall_delay", red_delay, 4);
    check32("ecall_hold_cycles", hold_cnt, 5);

    // irq masked, then enabled
    csr_write(A_MSTATUS, 32'h0);
    inst_addr_i = 32'h200;
    irq_i = 1;
    saved_red = red_cnt;
    idle(5);
    check32("irq_masked_no_redirect", red_cnt, saved_red);
    csr_write(A_MSTATUS, 32'h8);
    idle(7);
    check32("irq_mcause", csr_mcause, 32'h8000_000B);
    check32("irq_mepc", csr_mepc, 32'h200);
    irq_i = 0;

    // ecall and irq together: ecall wins, irq held off by MIE=0
    csr_write(A_MSTATUS, 32'h8);
    irq_i = 1;
    issue(ECALL, 32'h300);
    idle(10);
    check32("ecall_vs_irq_mcause", csr_mcause, 32'd11);
    check32("ecall_vs_irq_mepc", csr_mepc, 32'h300);
    irq_i = 0;

    // mret
    csr_write(A_MSTATUS, 32'h80);
    csr_write(A_MEPC, 32'h104);
    issue(MRET, 32'h50);
    idle(4);
    check32("mret_mstatus", csr_mstatus, 32'h88);
    check32("mret_target", red_addr, 32'h104);
    check32("mret_delay", red_delay, 2);

    // reset in W_MCAUSE
    csr_write(A_MCAUSE, 32'h55);
    csr_write(A_MSTATUS, 32'h8);
    saved_red = red_cnt;
    saved_mcause = csr_mcause;
    issue(ECALL, 32'h500);   // now in W_MEPC
    idle(1);                 // now in W_MCAUSE
    rst = 1;
    idle(1);
    rst = 0;
    idle(6);
    check32("rst_mepc_committed", csr_mepc, 32'h500);
    check32("rst_mcause_untouched", csr_mcause, saved_mcause);
    check32("rst_mstatus_untouched", csr_mstatus, 32'h8);
    check32("rst_no_redirect", red_cnt, saved_red);

    // interrupt with mtvec mode bits = 01
    csr_write(A_MTVEC, 32'h401);
    irq_i = 1;
    idle(1);
    irq_i = 0;
    idle(6);
`ifdef CLINT_VECTORED_EN
    check32("irq_vectored", red_addr, 32'h42C);
`else
    check32("irq_direct", red_addr, 32'h400);
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      inst_i = (r < 6) ? ECALL : (r < 12) ? EBREAK : (r < 20) ? MRET :
               (r < 24) ? $urandom : NOP;
      inst_addr_i = {$urandom_range(0, 32'h3FFF), 2'b00};
      jump_flag_i = ($urandom_range(0, 3) == 0);
      jump_addr_i = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 7) == 0) irq_i = ~irq_i;
      rst = ($urandom_range(0, 199) == 0);
      core_we = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: begin core_addr = A_MSTATUS; core_data = $urandom; end
        1: begin core_addr = A_MEPC;    core_data = $urandom; end
        2: begin core_addr = A_MTVEC;   core_data = {$urandom_range(0, 32'hFFFF), 1'b0, 1'($urandom_range(0, 1))}; end
        default: begin core_addr = A_MCAUSE; core_data = $urandom; end
      endcase
      @(posedge clk); #1;
    end
    inst_i = NOP; irq_i = 0; rst = 0; core_we = 0; jump_flag_i = 0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
